// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter advanced by rising edges of the divider's tick level.
// Supports start/stop, load, sync clear, wrap or saturate at the limits, and a terminal-count pulse.
module bcd_tick_counter #(
    parameter int MAX_COUNT = 99
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick_in,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_up_down,
    input  logic       i_wrap_en,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic [7:0] o_count_bcd,
    output logic       o_running,
    output logic       o_halted,
    output logic       o_tc
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
    localparam logic [7:0] MAX_BCD  = {MAX_TENS, MAX_ONES};

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUNNING,
        ST_HALTED
    } state_t;

    state_t     r_state;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_tick_q;
    logic       r_tc;

    logic       w_tick_rise;
    logic       w_step;
    logic       w_at_max;
    logic       w_at_zero;
    logic       w_load_ok;
    logic [7:0] w_load_bcd;
    logic [7:0] w_up_bcd;
    logic [7:0] w_down_bcd;

    assign w_tick_rise = i_tick_in & ~r_tick_q;
    assign w_step      = (r_state == ST_RUNNING) & w_tick_rise & ~i_clear & ~i_load & ~i_stop;
    assign w_at_max    = ({r_tens, r_ones} == MAX_BCD);
    assign w_at_zero   = ({r_tens, r_ones} == 8'h00);

    // With both digits valid BCD, plain binary compare of the byte orders the same as decimal.
    assign w_load_ok   = (i_load_val[7:4] <= 4'd9) && (i_load_val[3:0] <= 4'd9) &&
                         (i_load_val <= MAX_BCD);
    assign w_load_bcd  = w_load_ok ? i_load_val : MAX_BCD;

    always_comb begin
        w_up_bcd   = {r_tens, r_ones};
        w_down_bcd = {r_tens, r_ones};
        if (r_ones == 4'd9) begin
            w_up_bcd = {r_tens + 4'd1, 4'd0};
        end else begin
            w_up_bcd = {r_tens, r_ones + 4'd1};
        end
        if (r_ones == 4'd0) begin
            w_down_bcd = {r_tens - 4'd1, 4'd9};
        end else begin
            w_down_bcd = {r_tens, r_ones - 4'd1};
        end
    end

    // tick_q resets high so a tick level already high at reset release is not seen as an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_STOPPED;
            r_tens   <= 4'd0;
            r_ones   <= 4'd0;
            r_tick_q <= 1'b1;
            r_tc     <= 1'b0;
        end else begin
            r_tick_q <= i_tick_in;
            r_tc     <= 1'b0;
            if (i_clear) begin
                r_tens <= 4'd0;
                r_ones <= 4'd0;
                if (r_state == ST_HALTED) r_state <= ST_STOPPED;
            end else if (i_load) begin
                r_tens <= w_load_bcd[7:4];
                r_ones <= w_load_bcd[3:0];
                if (r_state == ST_HALTED) r_state <= ST_STOPPED;
            end else if (i_stop) begin
                if (r_state == ST_RUNNING) r_state <= ST_STOPPED;
            end else begin
                if (i_start && (r_state == ST_STOPPED)) r_state <= ST_RUNNING;
                if (w_step) begin
                    if (i_up_down) begin
                        if (w_at_max) begin
                            r_tc <= 1'b1;
                            if (i_wrap_en) begin
                                r_tens <= 4'd0;
                                r_ones <= 4'd0;
                            end else begin
                                r_state <= ST_HALTED;
                            end
                        end else begin
                            r_tens <= w_up_bcd[7:4];
                            r_ones <= w_up_bcd[3:0];
                        end
                    end else begin
                        if (w_at_zero) begin
                            r_tc <= 1'b1;
                            if (i_wrap_en) begin
                                r_tens <= MAX_TENS;
                                r_ones <= MAX_ONES;
                            end else begin
                                r_state <= ST_HALTED;
                            end
                        end else begin
                            r_tens <= w_down_bcd[7:4];
                            r_ones <= w_down_bcd[3:0];
                        end
                    end
                end
            end
        end
    end

    assign o_count_bcd = {r_tens, r_ones};
    assign o_running   = (r_state == ST_RUNNING);
    assign o_halted    = (r_state == ST_HALTED);
    assign o_tc        = r_tc;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: two instances (MAX_COUNT 99 and 59) share stimulus and are
// checked each cycle against a decimal-arithmetic model, plus directed literal checks.
module tb_bcd_tick_counter;

    localparam int STOPPED = 0;
    localparam int RUNNING = 1;
    localparam int HALTED  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tickIn = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       upDown = 1'b1;
    logic       wrapEn = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] loadVal = 8'h00;

    logic [7:0] countA, countB;
    logic       runA, runB, haltA, haltB, tcA, tcB;

    int checks = 0;
    int failures = 0;

    int maxOf [2] = '{99, 59};
    int mVal  [2];
    int mState[2];
    bit mTc   [2];
    bit prevTick;

    always #5 clk = ~clk;

    bcd_tick_counter #(.MAX_COUNT(99)) dutA (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick_in(tickIn), .i_start(start), .i_stop(stop),
        .i_up_down(upDown), .i_wrap_en(wrapEn), .i_clear(clear), .i_load(load),
        .i_load_val(loadVal), .o_count_bcd(countA), .o_running(runA), .o_halted(haltA),
        .o_tc(tcA)
    );

    bcd_tick_counter #(.MAX_COUNT(59)) dutB (
        .i_clk(clk), .i_rst_n(rst_n), .i_tick_in(tickIn), .i_start(start), .i_stop(stop),
        .i_up_down(upDown), .i_wrap_en(wrapEn), .i_clear(clear), .i_load(load),
        .i_load_val(loadVal), .o_count_bcd(countB), .o_running(runB), .o_halted(haltB),
        .o_tc(tcB)
    );

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int loadValue(input logic [7:0] lv, input int maxc);
        int tens = int'(lv[7:4]);
        int ones = int'(lv[3:0]);
        if (tens > 9 || ones > 9 || (tens * 10 + ones) > maxc) return maxc;
        return tens * 10 + ones;
    endfunction

    // Model advances on the same edge as the DUTs, then outputs are compared 1ns later.
    always @(posedge clk) begin
        bit rise;
        rise = tickIn & ~prevTick;
        for (int i = 0; i < 2; i++) begin
            mTc[i] = 1'b0;
            if (!rst_n) begin
                mVal[i]   = 0;
                mState[i] = STOPPED;
            end else if (clear) begin
                mVal[i] = 0;
                if (mState[i] == HALTED) mState[i] = STOPPED;
            end else if (load) begin
                mVal[i] = loadValue(loadVal, maxOf[i]);
                if (mState[i] == HALTED) mState[i] = STOPPED;
            end else if (stop) begin
                if (mState[i] == RUNNING) mState[i] = STOPPED;
            end else if (start && mState[i] == STOPPED) begin
                mState[i] = RUNNING;
            end else if (mState[i] == RUNNING && rise) begin
                if (upDown) begin
                    if (mVal[i] == maxOf[i]) begin
                        mTc[i] = 1'b1;
                        if (wrapEn) mVal[i] = 0; else mState[i] = HALTED;
                    end else begin
                        mVal[i] = mVal[i] + 1;
                    end
                end else begin
                    if (mVal[i] == 0) begin
                        mTc[i] = 1'b1;
                        if (wrapEn) mVal[i] = maxOf[i]; else mState[i] = HALTED;
                    end else begin
                        mVal[i] = mVal[i] - 1;
                    end
                end
            end
        end
        prevTick = rst_n ? tickIn : 1'b1;
        #1;
        checkOutput("countA", countA, toBcd(mVal[0]));
        checkOutput("runA", 8'(runA), 8'(mState[0] == RUNNING));
        checkOutput("haltA", 8'(haltA), 8'(mState[0] == HALTED));
        checkOutput("tcA", 8'(tcA), 8'(mTc[0]));
        checkOutput("countB", countB, toBcd(mVal[1]));
        checkOutput("runB", 8'(runB), 8'(mState[1] == RUNNING));
        checkOutput("haltB", 8'(haltB), 8'(mState[1] == HALTED));
        checkOutput("tcB", 8'(tcB), 8'(mTc[1]));
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1; @(negedge clk); clear = 1'b0;
    endtask

    task automatic pulseLoad(input logic [7:0] v);
        loadVal = v; load = 1'b1; @(negedge clk); load = 1'b0;
    endtask

    // Rising half of a tick: the step lands on the next posedge, tc is visible on return.
    task automatic tickRise();
        tickIn = 1'b1; @(negedge clk); tickIn = 1'b0;
    endtask

    task automatic tick();
        tickRise(); @(negedge clk);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tickIn  = 1'($urandom_range(0, 1));
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 15) == 0);
            clear   = ($urandom_range(0, 39) == 0);
            load    = ($urandom_range(0, 19) == 0);
            loadVal = ($urandom_range(0, 1) == 0) ? 8'($urandom)
                                                  : toBcd(int'($urandom_range(0, 99)));
            if ($urandom_range(0, 9) == 0) upDown = ~upDown;
            if ($urandom_range(0, 9) == 0) wrapEn = ~wrapEn;
            rst_n = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; tickIn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        idle(2);
        // Release reset with the tick level already high: no edge may be seen.
        rst_n = 1'b1;
        idle(3);
        checkOutput("lit_reset_hold", countA, 8'h00);
        tickIn = 1'b0;
        pulseStart();
        tick(); tick(); tick();
        checkOutput("lit_three_ticks", countA, 8'h03);

        // Up with wrap from 98.
        upDown = 1'b1; wrapEn = 1'b1;
        pulseLoad(8'h98);
        checkOutput("lit_load98_clampB", countB, 8'h59);
        tick();
        checkOutput("lit_up_99", countA, 8'h99);
        tickRise();
        checkOutput("lit_wrap_00", countA, 8'h00);
        checkOutput("lit_wrap_tc", 8'(tcA), 8'h01);
        @(negedge clk);
        checkOutput("lit_tc_one_cycle", 8'(tcA), 8'h00);

        // Down without wrap from 01 to saturation.
        upDown = 1'b0; wrapEn = 1'b0;
        pulseLoad(8'h01);
        tickRise();
        checkOutput("lit_land_zero_no_tc", 8'(tcA), 8'h00);
        @(negedge clk);
        tickRise();
        checkOutput("lit_sat_tc", 8'(tcA), 8'h01);
        checkOutput("lit_sat_halted", 8'(haltA), 8'h01);
        @(negedge clk);
        tick();
        checkOutput("lit_sat_hold", countA, 8'h00);
        pulseStart();
        checkOutput("lit_halt_ignores_start", 8'(haltA), 8'h01);
        pulseClear();
        checkOutput("lit_clear_unhalts", 8'(haltA | runA), 8'h00);

        // Invalid load clamps to the limit, then wraps up to 00.
        pulseLoad(8'h7A);
        checkOutput("lit_clamp_A", countA, 8'h99);
        checkOutput("lit_clamp_B", countB, 8'h59);
        upDown = 1'b1; wrapEn = 1'b1;
        pulseStart();
        tick();
        checkOutput("lit_wrapB_00", countB, 8'h00);

        // Decimal carry and borrow.
        pulseLoad(8'h09);
        tick();
        checkOutput("lit_carry_10", countA, 8'h10);
        upDown = 1'b0;
        tick();
        checkOutput("lit_borrow_09", countA, 8'h09);

        // Clear coinciding with a tick edge drops the step.
        tickIn = 1'b1; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; tickIn = 1'b0;
        checkOutput("lit_clear_drops_step", countA, 8'h00);
        upDown = 1'b1;
        @(negedge clk);
        tick(); tick();
        checkOutput("lit_after_clear_02", countA, 8'h02);

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("lit_async_count", countA, 8'h00);
        checkOutput("lit_async_running", 8'(runA), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(3000);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
